// File: rtl/sqrt_arbiter.sv
// Round-robin scheduler sharing one sequential 8-bit square-root core among N requesters.
// It grants one requester at a time, launches the core, tracks the core's busy line and returns the result.
module sqrt_arbiter #(
    parameter int N   = 4,
    parameter int TMO = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic [8*N-1:0] a_i,
    output logic [N-1:0]   ack_o,
    output logic [N-1:0]   done_o,
    output logic [3:0]     res_o,
    output logic           err_o,
    output logic           busy_o,
    output logic           core_start_o,
    output logic [7:0]     core_a_o,
    input  logic           core_busy_i,
    input  logic [3:0]     core_y_i
);
    localparam int IDX_W = $clog2(N);
    localparam int TMR_W = $clog2(TMO + 1);
    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);
    localparam logic [TMR_W-1:0] TMO_VAL  = TMR_W'(TMO);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [IDX_W-1:0] last_r, last_s;
    logic [IDX_W-1:0] cur_r, cur_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [N-1:0]     ack_r, ack_s;
    logic [N-1:0]     done_r, done_s;
    logic [3:0]       res_r, res_s;
    logic             err_r, err_s;
    logic             busy_r, busy_s;
    logic             start_r, start_s;
    logic [7:0]       core_a_r, core_a_s;

    logic             grant_vld_s;
    logic [IDX_W-1:0] grant_idx_s;
    int               cand_s;

    // Round-robin winner: scan downward so the candidate closest after last_r is assigned last and wins.
    always_comb begin
        cand_s      = 0;
        grant_vld_s = |req_i;
        grant_idx_s = '0;
        for (int i = N; i >= 1; i--) begin
            cand_s      = (int'(last_r) + i) % N;
            grant_idx_s = req_i[cand_s] ? IDX_W'(cand_s) : grant_idx_s;
        end
    end

    // Next-state and next-output decode for the scheduling FSM.
    always_comb begin
        state_s  = state_r;
        last_s   = last_r;
        cur_s    = cur_r;
        timer_s  = timer_r;
        ack_s    = '0;
        done_s   = '0;
        start_s  = 1'b0;
        res_s    = res_r;
        err_s    = err_r;
        core_a_s = core_a_r;
        case (state_r)
            IDLE: begin
                if (grant_vld_s) begin
                    ack_s    = ONE_N << grant_idx_s;
                    start_s  = 1'b1;
                    core_a_s = a_i[{grant_idx_s, 3'b000} +: 8];
                    cur_s    = grant_idx_s;
                    last_s   = grant_idx_s;
                    state_s  = LAUNCH;
                end else begin
                    state_s  = IDLE;
                end
            end
            LAUNCH: begin
                timer_s = '0;
                state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A core that never raises busy is reported as an error with a zero result.
                if (core_busy_i) begin
                    state_s = WAIT_DONE;
                end else if (timer_r == TMO_VAL) begin
                    err_s   = 1'b1;
                    res_s   = 4'd0;
                    done_s  = ONE_N << cur_r;
                    state_s = RESP;
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (core_busy_i) begin
                    state_s = WAIT_DONE;
                end else begin
                    res_s   = core_y_i;
                    err_s   = 1'b0;
                    done_s  = ONE_N << cur_r;
                    state_s = RESP;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r  <= IDLE;
            last_r   <= LAST_RST;
            cur_r    <= '0;
            timer_r  <= '0;
            ack_r    <= '0;
            done_r   <= '0;
            res_r    <= 4'd0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            start_r  <= 1'b0;
            core_a_r <= 8'd0;
        end else begin
            state_r  <= state_s;
            last_r   <= last_s;
            cur_r    <= cur_s;
            timer_r  <= timer_s;
            ack_r    <= ack_s;
            done_r   <= done_s;
            res_r    <= res_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
            start_r  <= start_s;
            core_a_r <= core_a_s;
        end
    end

    assign ack_o        = ack_r;
    assign done_o       = done_r;
    assign res_o        = res_r;
    assign err_o        = err_r;
    assign busy_o       = busy_r;
    assign core_start_o = start_r;
    assign core_a_o     = core_a_r;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed, table-driven bench for sqrt_arbiter with a behavioural sequential sqrt core attached.
module tb_sqrt_arbiter;
    localparam int N   = 4;
    localparam int TMO = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [3:0]   req_i = 4'd0;
    logic [31:0]  a_i   = 32'd0;
    logic [3:0]   ack_o, done_o, res_o;
    logic         err_o, busy_o, core_start_o;
    logic [7:0]   core_a_o;
    logic         core_busy_i;
    logic [3:0]   core_y_i;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat     = 2;
    logic stuck   = 1'b0;
    int   cnt_r;
    logic [3:0] y_true;
    int   ack_cnt  [N] = '{default: 0};
    int   done_cnt [N] = '{default: 0};

    typedef struct {
        logic        rst;
        logic        hold;
        logic        stuck;
        int          lat;
        logic [3:0]  req;
        logic [31:0] a;
        int          g;
        logic [7:0]  ea;
        logic [3:0]  res;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    always #5 clk_i = ~clk_i;

    sqrt_arbiter #(.N(N), .TMO(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_i(a_i),
        .ack_o(ack_o), .done_o(done_o), .res_o(res_o), .err_o(err_o), .busy_o(busy_o),
        .core_start_o(core_start_o), .core_a_o(core_a_o),
        .core_busy_i(core_busy_i), .core_y_i(core_y_i)
    );

    function automatic logic [3:0] isqrt(input logic [7:0] v);
        logic [3:0] r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i * i <= int'(v)) r = 4'(i);
        end
        return r;
    endfunction

    // Core model: busy rises the edge after start, falls lat edges later; y is garbage until then.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            core_busy_i <= 1'b0;
            cnt_r       <= 0;
            core_y_i    <= 4'd0;
            y_true      <= 4'd0;
        end else if (core_start_o && !stuck) begin
            core_busy_i <= 1'b1;
            cnt_r       <= lat;
            y_true      <= isqrt(core_a_o);
            core_y_i    <= ~isqrt(core_a_o);
        end else if (core_busy_i) begin
            if (cnt_r == 1) begin
                core_busy_i <= 1'b0;
                core_y_i    <= y_true;
            end
            cnt_r <= cnt_r - 1;
        end
    end

    // Count ack/done pulses per requester.
    always @(negedge clk_i) begin
        for (int k = 0; k < N; k++) begin
            if (ack_o[k])  ack_cnt[k]  <= ack_cnt[k] + 1;
            if (done_o[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        req_i = 4'd0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        int cyc;
        if (v.rst) do_reset();
        lat   = v.lat;
        stuck = v.stuck;
        req_i = v.req;
        a_i   = v.a;
        cyc   = 0;
        do begin @(negedge clk_i); cyc++; end while (ack_o == 4'd0 && cyc < 20);
        check("ack", 32'(ack_o), 32'(4'd1 << v.g));
        check("ack_lat", 32'(cyc), 32'd1);
        check("start", 32'(core_start_o), 32'd1);
        check("core_a", 32'(core_a_o), 32'(v.ea));
        if (!v.hold) req_i[v.g] = 1'b0;
        @(negedge clk_i);
        cyc = 1;
        check("strobe_off", 32'({ack_o, core_start_o}), 32'd0);
        check("busy_on", 32'(busy_o), 32'd1);
        do begin @(negedge clk_i); cyc++; end while (done_o == 4'd0 && cyc < 100);
        check("done", 32'(done_o), 32'(4'd1 << v.g));
        check("res", 32'(res_o), 32'(v.res));
        check("err", 32'(err_o), 32'(v.err));
        check("core_a_hold", 32'(core_a_o), 32'(v.ea));
        if (v.stuck) check("tmo_lat", 32'(cyc), 32'(TMO + 2));
        @(negedge clk_i);
        check("done_clr", 32'(done_o), 32'd0);
        check("busy_off", 32'(busy_o), 32'd0);
        check("res_hold", 32'(res_o), 32'(v.res));
    endtask

    localparam logic [31:0] A_ALL = {8'd16, 8'd255, 8'd63, 8'd0};
    localparam logic [31:0] A_FR  = {8'd0, 8'd49, 8'd9, 8'd0};

    initial begin
        int cyc;
        int snap_a;
        int snap_d;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd100}, 0, 8'd100, 4'd10, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2, 4'b1111, A_ALL, 0, 8'd0,   4'd0,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2, 4'b1111, A_ALL, 1, 8'd63,  4'd7,  1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4, 4'b1111, A_ALL, 2, 8'd255, 4'd15, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1, 4'b1111, A_ALL, 3, 8'd16,  4'd4,  1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2, 4'b1111, A_ALL, 0, 8'd0,   4'd0,  1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3, 4'b0010, A_FR,  1, 8'd9,   4'd3,  1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3, 4'b0110, A_FR,  2, 8'd49,  4'd7,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3, 4'b0110, A_FR,  1, 8'd9,   4'd3,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 3, 4'b0110, A_FR,  2, 8'd49,  4'd7,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2, 4'b1000, {8'd200, 8'd0, 8'd0, 8'd0}, 3, 8'd200, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd81},  0, 8'd81,  4'd9, 1'b0};

        // Outputs under reset, with every request asserted.
        rst_i = 1'b0;
        req_i = 4'hF;
        a_i   = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk_i);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_res", 32'(res_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_start", 32'(core_start_o), 32'd0);
        check("rst_core_a", 32'(core_a_o), 32'd0);

        for (int i = 0; i < 12; i++) apply(vecs[i]);

        // Reset during WAIT_DONE: everything clears, no done, pointer back to N-1.
        lat   = 10;
        stuck = 1'b0;
        req_i = 4'b0010;
        a_i   = {8'd0, 8'd0, 8'd100, 8'd0};
        cyc   = 0;
        do begin @(negedge clk_i); cyc++; end while (ack_o == 4'd0 && cyc < 20);
        check("mid_ack", 32'(ack_o), 32'b0010);
        req_i = 4'd0;
        repeat (4) @(negedge clk_i);
        check("mid_busy", 32'(busy_o), 32'd1);
        snap_d = done_cnt[1];
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_outs", 32'({ack_o, done_o, res_o, err_o, busy_o, core_start_o, core_a_o}), 32'd0);
        rst_i = 1'b1;
        repeat (15) @(negedge clk_i);
        check("mid_no_done", 32'(done_cnt[1]), 32'(snap_d));
        check("mid_idle", 32'(busy_o), 32'd0);
        apply('{1'b0, 1'b0, 1'b0, 2, 4'b1001, {8'd30, 8'd0, 8'd0, 8'd50}, 0, 8'd50, 4'd7, 1'b0});
        apply('{1'b0, 1'b0, 1'b0, 2, 4'b1000, {8'd30, 8'd0, 8'd0, 8'd50}, 3, 8'd30, 4'd5, 1'b0});

        // A request raised and dropped while another operation is in flight is never served.
        lat   = 6;
        req_i = 4'b0001;
        a_i   = {8'd0, 8'd25, 8'd0, 8'd64};
        cyc   = 0;
        do begin @(negedge clk_i); cyc++; end while (ack_o == 4'd0 && cyc < 20);
        check("drop_ack", 32'(ack_o), 32'b0001);
        snap_a = ack_cnt[2];
        snap_d = done_cnt[2];
        req_i = 4'b0100;
        repeat (3) @(negedge clk_i);
        req_i = 4'b0000;
        cyc   = 0;
        do begin @(negedge clk_i); cyc++; end while (done_o == 4'd0 && cyc < 40);
        check("drop_done", 32'(done_o), 32'b0001);
        check("drop_res", 32'(res_o), 32'd8);
        repeat (10) @(negedge clk_i);
        check("drop_no_ack", 32'(ack_cnt[2]), 32'(snap_a));
        check("drop_no_done", 32'(done_cnt[2]), 32'(snap_d));
        check("drop_idle", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
